// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Multi-cycle MIPS control FSM. Sequences FETCH / DECODE / EXEC / MEM / WB for
// one instruction at a time and drives the datapath strobes, the unified
// memory port request lines and the ALU select code. The ALU zero flag is
// consumed in the BRANCH state to decide whether the PC loads the branch
// target (the ALU is programmed with beq/bne so zflag already means "taken").
//
// Optional feature macro: CTRL_TRAP_EN
//   defined   : an illegal instruction parks the FSM in TRAP (trap=1, all
//               strobes 0, no retire); only reset leaves TRAP.
//   undefined : an illegal instruction behaves as a NOP (retires); trap is 0.
//
// Parameters
//   RETIRE_W     width of the retired-instruction counter
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   instr        in   [31:0] IR output, or memory read data during FETCH
//   zflag        in   ALU zero flag (taken condition for beq/bne)
//   mem_ack      in   memory completes the current read/write this cycle
//   alu_sel      out  [5:0] funct (R-type) or opcode (I-type / branch)
//   alu_src_imm  out  ALU B operand is the extended immediate
//   pc_we        out  PC load enable
//   pc_src       out  [1:0] 0 = PC+4, 1 = branch target, 2 = jump target
//   ir_we        out  instruction register load
//   iord         out  memory address select: 0 = PC, 1 = ALU result reg
//   mem_re       out  memory read request, held until mem_ack
//   mem_we       out  memory write request, held until mem_ack
//   reg_we       out  register file write strobe
//   reg_dst      out  1 = rd, 0 = rt
//   mem_to_reg   out  writeback data comes from memory
//   trap         out  illegal instruction latched (CTRL_TRAP_EN builds only)
//   instr_count  out  [RETIRE_W-1:0] retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instr,
    input  logic                zflag,
    input  logic                mem_ack,
    output logic [5:0]          alu_sel,
    output logic                alu_src_imm,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic                ir_we,
    output logic                iord,
    output logic                mem_re,
    output logic                mem_we,
    output logic                reg_we,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                trap,
    output logic [RETIRE_W-1:0] instr_count
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [1:0] PCS_SEQ    = 2'd0;
    localparam logic [1:0] PCS_BRANCH = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5,
        ST_JUMP   = 3'd6,
        ST_TRAP   = 3'd7
    } state_t;

    // Supported R-type ALU operations.
    function automatic logic is_r_alu(input logic [5:0] fn);
        logic ok;
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Supported I-type instructions that go through EXEC.
    function automatic logic is_i_op(input logic [5:0] op);
        logic ok;
        case (op)
            OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [5:0]          opcode_r;
    logic [5:0]          funct_r;
    logic [RETIRE_W-1:0] count_r;

    logic                rtype_s;
    logic                lw_s;
    logic                sw_s;
    logic                retire_s;

    logic [5:0]          alu_sel_s;
    logic                alu_src_imm_s;
    logic                pc_we_s;
    logic [1:0]          pc_src_s;
    logic                ir_we_s;
    logic                iord_s;
    logic                mem_re_s;
    logic                mem_we_s;
    logic                reg_we_s;
    logic                reg_dst_s;
    logic                mem_to_reg_s;
    logic                trap_s;

    assign rtype_s = (opcode_r == OP_RTYPE);
    assign lw_s    = (opcode_r == OP_LW);
    assign sw_s    = (opcode_r == OP_SW);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Opcode/funct latch, loaded together with the IR at the end of FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_r <= 6'd0;
            funct_r  <= 6'd0;
        end else if ((state_r == ST_FETCH) && mem_ack) begin
            opcode_r <= instr[31:26];
            funct_r  <= instr[5:0];
        end else begin
            opcode_r <= opcode_r;
            funct_r  <= funct_r;
        end
    end

    // Retired-instruction counter; wraps naturally at 2^RETIRE_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (retire_s) begin
            count_r <= count_r + RETIRE_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Next-state, retire and Moore output decode.
    always_comb begin
        state_s       = state_r;
        retire_s      = 1'b0;
        alu_sel_s     = 6'd0;
        alu_src_imm_s = 1'b0;
        pc_we_s       = 1'b0;
        pc_src_s      = PCS_SEQ;
        ir_we_s       = 1'b0;
        iord_s        = 1'b0;
        mem_re_s      = 1'b0;
        mem_we_s      = 1'b0;
        reg_we_s      = 1'b0;
        reg_dst_s     = 1'b0;
        mem_to_reg_s  = 1'b0;
        trap_s        = 1'b0;

        case (state_r)
            ST_FETCH: begin
                mem_re_s = 1'b1;
                iord_s   = 1'b0;
                // IR and PC+4 commit in the same cycle the read data arrives.
                ir_we_s  = mem_ack;
                pc_we_s  = mem_ack;
                pc_src_s = PCS_SEQ;
                if (mem_ack) begin
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_FETCH;
                end
            end

            ST_DECODE: begin
                // instr is the IR output here; an all-zero word is the NOP.
                if (instr == 32'h0000_0000) begin
                    state_s  = ST_FETCH;
                    retire_s = 1'b1;
                end else if ((rtype_s && is_r_alu(funct_r)) || is_i_op(opcode_r)) begin
                    state_s = ST_EXEC;
                end else if ((opcode_r == OP_BEQ) || (opcode_r == OP_BNE)) begin
                    state_s = ST_BRANCH;
                end else if (opcode_r == OP_J) begin
                    state_s = ST_JUMP;
                end else begin
`ifdef CTRL_TRAP_EN
                    state_s = ST_TRAP;
`else
                    state_s  = ST_FETCH;
                    retire_s = 1'b1;
`endif
                end
            end

            ST_EXEC: begin
                if (rtype_s) begin
                    alu_sel_s     = funct_r;
                    alu_src_imm_s = 1'b0;
                end else begin
                    alu_sel_s     = opcode_r;
                    alu_src_imm_s = 1'b1;
                end
                if (lw_s || sw_s) begin
                    state_s = ST_MEM;
                end else begin
                    state_s = ST_WB;
                end
            end

            ST_MEM: begin
                iord_s   = 1'b1;
                // Only lw/sw reach MEM, so the two requests are exclusive.
                mem_re_s = lw_s;
                mem_we_s = sw_s;
                if (mem_ack) begin
                    if (lw_s) begin
                        state_s = ST_WB;
                    end else begin
                        state_s  = ST_FETCH;
                        retire_s = 1'b1;
                    end
                end else begin
                    state_s = ST_MEM;
                end
            end

            ST_WB: begin
                reg_we_s     = 1'b1;
                reg_dst_s    = rtype_s;
                mem_to_reg_s = lw_s;
                state_s      = ST_FETCH;
                retire_s     = 1'b1;
            end

            ST_BRANCH: begin
                alu_sel_s = opcode_r;
                pc_we_s   = zflag;
                pc_src_s  = PCS_BRANCH;
                state_s   = ST_FETCH;
                retire_s  = 1'b1;
            end

            ST_JUMP: begin
                pc_we_s  = 1'b1;
                pc_src_s = PCS_JUMP;
                state_s  = ST_FETCH;
                retire_s = 1'b1;
            end

            ST_TRAP: begin
`ifdef CTRL_TRAP_EN
                trap_s  = 1'b1;
                state_s = ST_TRAP;
`else
                // Unreachable without the trap feature; recover to FETCH.
                state_s = ST_FETCH;
`endif
            end

            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    // While reset is asserted the state already reads FETCH, so the request
    // lines are additionally forced low to make every output 0 and to drop an
    // in-flight memory request immediately.
    assign alu_sel     = alu_sel_s & {6{rst_n}};
    assign alu_src_imm = alu_src_imm_s & rst_n;
    assign pc_we       = pc_we_s & rst_n;
    assign pc_src      = pc_src_s & {2{rst_n}};
    assign ir_we       = ir_we_s & rst_n;
    assign iord        = iord_s & rst_n;
    assign mem_re      = mem_re_s & rst_n;
    assign mem_we      = mem_we_s & rst_n;
    assign reg_we      = reg_we_s & rst_n;
    assign reg_dst     = reg_dst_s & rst_n;
    assign mem_to_reg  = mem_to_reg_s & rst_n;
    assign trap        = trap_s & rst_n;
    assign instr_count = count_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Directed bench for mips_multicycle_ctrl. The bench plays the memory and the
// IR: instr carries the instruction word for the whole instruction, mem_ack
// and zflag are driven per cycle. Outputs are sampled 1 time unit after the
// falling edge. A second instance with RETIRE_W=4 covers counter wrap.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam logic [31:0] I_ADD  = 32'h0022_1820; // add  $3,$1,$2
    localparam logic [31:0] I_LW   = 32'h8C22_0004; // lw   $2,4($1)
    localparam logic [31:0] I_SW   = 32'hAC22_0004; // sw   $2,4($1)
    localparam logic [31:0] I_BEQ  = 32'h1022_0003; // beq  $1,$2,3
    localparam logic [31:0] I_BNE  = 32'h1422_0003; // bne  $1,$2,3
    localparam logic [31:0] I_J    = 32'h0800_0010; // j    0x10
    localparam logic [31:0] I_ORI  = 32'h3422_0005; // ori  $2,$1,5
    localparam logic [31:0] I_NOP  = 32'h0000_0000;
    localparam logic [31:0] I_ADDU = 32'h0022_1821; // funct 100001: unsupported
    localparam logic [31:0] I_ILL  = 32'hFC00_0000; // opcode 111111

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zflag;
    logic        mem_ack;
    logic [5:0]  alu_sel;
    logic        alu_src_imm;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        ir_we;
    logic        iord;
    logic        mem_re;
    logic        mem_we;
    logic        reg_we;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        trap;
    logic [31:0] instr_count;

    logic        rst4_n;
    logic [31:0] instr4;
    logic        zflag4;
    logic        mem_ack4;
    logic [5:0]  alu_sel4;
    logic        alu_src_imm4;
    logic        pc_we4;
    logic [1:0]  pc_src4;
    logic        ir_we4;
    logic        iord4;
    logic        mem_re4;
    logic        mem_we4;
    logic        reg_we4;
    logic        reg_dst4;
    logic        mem_to_reg4;
    logic        trap4;
    logic [3:0]  instr_count4;

    logic [17:0] obs;
    int          n_assert;
    int          n_fail;
    int          exp_cnt;

    mips_multicycle_ctrl #(.RETIRE_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zflag(zflag), .mem_ack(mem_ack),
        .alu_sel(alu_sel), .alu_src_imm(alu_src_imm), .pc_we(pc_we), .pc_src(pc_src),
        .ir_we(ir_we), .iord(iord), .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .trap(trap), .instr_count(instr_count)
    );

    mips_multicycle_ctrl #(.RETIRE_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .instr(instr4), .zflag(zflag4), .mem_ack(mem_ack4),
        .alu_sel(alu_sel4), .alu_src_imm(alu_src_imm4), .pc_we(pc_we4), .pc_src(pc_src4),
        .ir_we(ir_we4), .iord(iord4), .mem_re(mem_re4), .mem_we(mem_we4), .reg_we(reg_we4),
        .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4), .trap(trap4), .instr_count(instr_count4)
    );

    assign obs = {alu_sel, alu_src_imm, pc_we, pc_src, ir_we, iord,
                  mem_re, mem_we, reg_we, reg_dst, mem_to_reg, trap};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector, same field order as obs.
    function automatic logic [17:0] ev(input logic [5:0] sel, input logic imm,
                                       input logic pcwe, input logic [1:0] src,
                                       input logic irwe, input logic io,
                                       input logic re, input logic we,
                                       input logic rwe, input logic rd,
                                       input logic m2r, input logic tr);
        return {sel, imm, pcwe, src, irwe, io, re, we, rwe, rd, m2r, tr};
    endfunction

    localparam logic [17:0] V_ZERO  = 18'h0_0000;
    localparam logic [17:0] V_FWAIT = 18'b000000_0_0_00_0_0_1_0_0_0_0_0;
    localparam logic [17:0] V_FACK  = 18'b000000_0_1_00_1_0_1_0_0_0_0_0;
    localparam logic [17:0] V_TRAP  = 18'b000000_0_0_00_0_0_0_0_0_0_0_1;

    task automatic chk_out(input string tag, input logic [17:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] expv);
        n_assert++;
        assert (instr_count === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, instr_count, expv);
        end
    endtask

    task automatic chk_cnt4(input string tag, input logic [3:0] expv);
        n_assert++;
        assert (instr_count4 === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, instr_count4, expv);
        end
    endtask

    // Advance to the next falling edge, drive inputs, settle.
    task automatic cyc(input logic [31:0] i, input logic ack, input logic z);
        @(negedge clk);
        instr   = i;
        mem_ack = ack;
        zflag   = z;
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        rst_n    = 1'b0;
        rst4_n   = 1'b0;
        instr    = 32'h0;
        zflag    = 1'b0;
        mem_ack  = 1'b0;
        instr4   = 32'h0;
        zflag4   = 1'b0;
        mem_ack4 = 1'b1;

        // Reset: every output low, counter clear, mem_ack cannot leak through.
        #2;
        chk_out("reset_outs", V_ZERO);
        chk_cnt("reset_cnt", 32'd0);
        mem_ack = 1'b1;
        #1;
        chk_out("reset_ack_gated", V_ZERO);
        mem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_out("fetch_idle", V_FWAIT);

        // add: FETCH, DECODE, EXEC, WB with mem_ack tied high.
        cyc(I_ADD, 1'b1, 1'b0); chk_out("add_fetch", V_FACK); chk_cnt("add_cnt0", 32'd0);
        cyc(I_ADD, 1'b1, 1'b0); chk_out("add_decode", V_ZERO);
        cyc(I_ADD, 1'b1, 1'b0);
        chk_out("add_exec", ev(6'b100000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(I_ADD, 1'b1, 1'b0);
        chk_out("add_wb", ev(6'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        // Four cycles after the add fetch we are back in FETCH with one retire.
        cyc(I_LW, 1'b0, 1'b0); chk_out("lw_fetch_wait", V_FWAIT); chk_cnt("add_retired", 32'd1);

        // lw with a three-cycle memory delay in MEM.
        cyc(I_LW, 1'b1, 1'b0); chk_out("lw_fetch", V_FACK);
        cyc(I_LW, 1'b0, 1'b0); chk_out("lw_decode", V_ZERO);
        cyc(I_LW, 1'b0, 1'b0);
        chk_out("lw_exec", ev(6'b100011, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            cyc(I_LW, 1'b0, 1'b0);
            chk_out("lw_mem_wait", ev(6'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        cyc(I_LW, 1'b1, 1'b0);
        chk_out("lw_mem_ack", ev(6'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(I_LW, 1'b0, 1'b0);
        chk_out("lw_wb", ev(6'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        chk_cnt("lw_cnt_before_retire", 32'd1);

        // beq taken.
        cyc(I_BEQ, 1'b1, 1'b1); chk_out("beq_fetch", V_FACK); chk_cnt("lw_retired", 32'd2);
        cyc(I_BEQ, 1'b0, 1'b1); chk_out("beq_decode", V_ZERO);
        cyc(I_BEQ, 1'b0, 1'b1);
        chk_out("beq_branch", ev(6'b000100, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // bne not taken.
        cyc(I_BNE, 1'b1, 1'b0); chk_out("bne_fetch", V_FACK); chk_cnt("beq_retired", 32'd3);
        cyc(I_BNE, 1'b0, 1'b0); chk_out("bne_decode", V_ZERO);
        cyc(I_BNE, 1'b0, 1'b0);
        chk_out("bne_branch", ev(6'b000101, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // j.
        cyc(I_J, 1'b1, 1'b0); chk_out("j_fetch", V_FACK); chk_cnt("bne_retired", 32'd4);
        cyc(I_J, 1'b0, 1'b0); chk_out("j_decode", V_ZERO);
        cyc(I_J, 1'b0, 1'b0);
        chk_out("j_jump", ev(6'd0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // sw aborted by reset in the middle of MEM.
        cyc(I_SW, 1'b1, 1'b0); chk_out("sw_fetch", V_FACK); chk_cnt("j_retired", 32'd5);
        cyc(I_SW, 1'b0, 1'b0); chk_out("sw_decode", V_ZERO);
        cyc(I_SW, 1'b0, 1'b0);
        chk_out("sw_exec", ev(6'b101011, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(I_SW, 1'b0, 1'b0);
        chk_out("sw_mem_wait", ev(6'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("sw_reset_drop", V_ZERO);
        chk_cnt("sw_reset_cnt", 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_out("sw_after_reset_fetch", V_FWAIT);
        chk_cnt("sw_not_retired", 32'd0);

        // ori: immediate operand, writes rt.
        cyc(I_ORI, 1'b1, 1'b0); chk_out("ori_fetch", V_FACK);
        cyc(I_ORI, 1'b0, 1'b0); chk_out("ori_decode", V_ZERO);
        cyc(I_ORI, 1'b0, 1'b0);
        chk_out("ori_exec", ev(6'b001101, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(I_ORI, 1'b0, 1'b0);
        chk_out("ori_wb", ev(6'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

        // NOP retires straight out of DECODE.
        cyc(I_NOP, 1'b1, 1'b0); chk_out("nop_fetch", V_FACK); chk_cnt("ori_retired", 32'd1);
        cyc(I_NOP, 1'b0, 1'b0); chk_out("nop_decode", V_ZERO);
        exp_cnt = 2;

        // Unsupported R-type funct.
        cyc(I_ADDU, 1'b1, 1'b0); chk_out("addu_fetch", V_FACK); chk_cnt("nop_retired", 32'(exp_cnt));
        cyc(I_ADDU, 1'b0, 1'b0); chk_out("addu_decode", V_ZERO);
`ifdef CTRL_TRAP_EN
        cyc(I_ILL, 1'b0, 1'b0); chk_out("addu_trap", V_TRAP); chk_cnt("addu_no_retire", 32'(exp_cnt));
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("trap_reset_clears", V_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
`else
        exp_cnt = exp_cnt + 1;
        cyc(I_ILL, 1'b0, 1'b0); chk_out("addu_as_nop", V_FWAIT); chk_cnt("addu_retired", 32'(exp_cnt));
`endif

        // Opcode 111111.
        cyc(I_ILL, 1'b1, 1'b0); chk_out("ill_fetch", V_FACK);
        cyc(I_ILL, 1'b0, 1'b0); chk_out("ill_decode", V_ZERO);
`ifdef CTRL_TRAP_EN
        for (int k = 0; k < 3; k++) begin
            cyc(I_ILL, 1'b1, 1'b0);
            chk_out("ill_trap_stuck", V_TRAP);
            chk_cnt("ill_no_retire", 32'(exp_cnt));
        end
`else
        exp_cnt = exp_cnt + 1;
        cyc(I_ILL, 1'b0, 1'b0); chk_out("ill_as_nop", V_FWAIT); chk_cnt("ill_retired", 32'(exp_cnt));
`endif

        // Counter wrap on the 4-bit instance: a NOP retires every 2 cycles.
        @(negedge clk);
        rst4_n = 1'b1;
        #1;
        chk_cnt4("wrap_start", 4'd0);
        repeat (30) @(negedge clk);
        #1;
        chk_cnt4("wrap_at_15", 4'd15);
        repeat (2) @(negedge clk);
        #1;
        chk_cnt4("wrap_to_0", 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
